if_id_elastic_stage: RTL and testbench
======================================

Name: if_id_elastic_stage

Overview:
- Next-generation IF/ID pipeline boundary: two-entry elastic (skid-buffered) register between fetch and decode, replacing the fixed always-advance register.
- Adds valid/ready handshake, synchronous flush for branch redirect, registered opcode-field slices, and saturating stall/bubble performance counters.
- Sits between the PC/instruction-memory fetch logic and the decode/register-file stage.

Parameters:
- PC_W, 32, width of PC payload.
- INSTR_W, 32, width of instruction payload.
- NOP_INSTR, 32'h0, instruction value presented whenever the stage holds no valid entry.
- CNT_W, 16, width of each performance counter.

Ports:
- clk, input, 1, pipeline clock; all state updates on the falling edge.
- rst, input, 1, reset: asynchronous, active-high.
- flush, input, 1, synchronous discard of all held and incoming entries.
- in_valid, input, 1, fetch presents an entry.
- in_ready, output, 1, stage can accept an entry this edge.
- in_pc, input, PC_W, fetched PC.
- in_instr, input, INSTR_W, fetched instruction.
- out_valid, output, 1, decode-side entry valid.
- out_ready, input, 1, decode consumes the entry this edge.
- out_pc, output, PC_W, PC of head entry.
- out_instr, output, INSTR_W, head instruction.
- out_type, output, 2, out_instr[31:30].
- out_op, output, 5, out_instr[29:25].
- stall_cnt, output, CNT_W, edges on which fetch was back-pressured.
- bubble_cnt, output, CNT_W, edges on which decode was ready but starved.

Behaviour:
- Storage: main entry (drives outputs) and skid entry; state from pkg: EMPTY, ONE, FULL.
- acc = in_valid & in_ready; con = out_valid & out_ready; both sampled at the falling edge.
- in_ready = (state != FULL), registered-state derived, no combinational path from out_ready.
- out_valid = (state != EMPTY).
- out_pc/out_instr come from the main register; out_type/out_op are slices of it.
- Transitions, flush = 0:
  - EMPTY: acc -> ONE, main <= in.
  - ONE: acc&con -> ONE, main <= in.
  - ONE: acc&!con -> FULL, skid <= in.
  - ONE: !acc&con -> EMPTY.
  - ONE: otherwise hold.
  - FULL: con -> ONE, main <= skid (no accept possible); otherwise hold.
- Entering EMPTY loads main with pc = 0, instr = NOP_INSTR.
- Flush: highest priority at any state -> EMPTY. Main is cleared as above; the skid is invalidated. An entry offered on the same edge is dropped (not accepted, not counted as stall). A consume on the flush edge still counts as a consume for decode.
- Latency: 1 falling edge from acceptance to out_valid when EMPTY. Full throughput, one entry per edge, when out_ready is held high.
- Ordering: strict FIFO; no entry is duplicated or lost except by flush.
- stall_cnt: +1 on each edge with in_valid & !in_ready & !flush; saturates at all-ones.
- bubble_cnt: +1 on each edge with out_ready & !out_valid & !flush; saturates at all-ones.
- Counters are cleared only by rst; flush does not clear them.
- rst (async, any time, including mid-transfer):
  - state = EMPTY, main pc = 0, main instr = NOP_INSTR, skid cleared.
  - in_ready = 1, out_valid = 0, out_pc = 0, out_instr = NOP_INSTR, out_type/out_op = NOP_INSTR slices, counters = 0.
- X on in_pc/in_instr when in_valid = 0 must not propagate into state.

Decomposition:
- Package pipe_pkg holds:
  - typedef enum {EMPTY, ONE, FULL} elastic_state_t;
  - localparams for type/op field positions (31:30, 29:25);
  - default NOP_INSTR constant, shared with the later ID/EX and EX/MEM elastic stages.
- One sub-module: pipe_sat_counter (parameter W; ports clk, rst, inc, cnt), instantiated twice.

Test Plan:
- Reset mid-FULL: load 2 entries with out_ready = 0, assert rst -> all outputs zero/NOP immediately (async), in_ready = 1, stall_cnt = 0.
- Streaming: out_ready = 1, feed PCs 0x0, 0x4, 0x8 with instr 0x8A000001, ... on consecutive edges -> identical sequence at the output one edge later. Check out_type = 2'b10 and out_op = 5'b00101. bubble_cnt increments only on the first edge.
- Back-pressure: out_ready = 0, offer 0x10, 0x14, 0x18 -> FULL after two edges, in_ready = 0, 0x18 held by fetch, stall_cnt = 1 per held edge. Release out_ready -> output 0x10, 0x14, 0x18 in order, none lost.
- Flush in FULL with in_valid = 1 offering 0x20 -> next state EMPTY, out_valid = 0, out_instr = NOP_INSTR, 0x20 not accepted, stall_cnt unchanged on that edge.
- Simultaneous accept+consume in ONE for 4 edges -> state stays ONE and outputs track input with 1-edge latency. Then force stall_cnt near 2^CNT_W-1 (CNT_W = 4 build) -> saturates at 4'hF.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline boundary registers
// (IF/ID now, ID/EX and EX/MEM later).
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } elastic_state_t;

  // Instruction field positions decoded at the stage boundary
  localparam int TYPE_HI = 31;
  localparam int TYPE_LO = 30;
  localparam int OP_HI   = 29;
  localparam int OP_LO   = 25;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating event counter, updated on the falling edge, cleared only by rst.
module pipe_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/if_id_elastic_stage.sv
// IF/ID boundary: two-entry skid-buffered register with flush and
// saturating stall/bubble counters. All state changes on the falling edge.
module if_id_elastic_stage
  import pipe_pkg::*;
#(
  parameter int                 PC_W      = 32,
  parameter int                 INSTR_W   = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEFAULT),
  parameter int                 CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [1:0]         out_type,
  output logic [4:0]         out_op,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   bubble_cnt,
  output elastic_state_t     state_dbg
);

  elastic_state_t     state, state_nxt;
  logic [PC_W-1:0]    main_pc, skid_pc;
  logic [INSTR_W-1:0] main_instr, skid_instr;

  logic acc, con;
  logic load_main_in, load_main_skid, clear_main;
  logic load_skid, clear_skid;

  // Handshake: a transfer happens on a falling edge where valid & ready are
  // both high; in_ready depends only on registered state, never on out_ready.
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign acc       = in_valid & in_ready;
  assign con       = out_valid & out_ready;

  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    clear_main     = 1'b0;
    load_skid      = 1'b0;
    clear_skid     = 1'b0;
    if (flush) begin
      state_nxt  = EMPTY;
      clear_main = 1'b1;
      clear_skid = 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (acc) begin
            state_nxt    = ONE;
            load_main_in = 1'b1;
          end
        end
        ONE: begin
          if (acc && con) begin
            load_main_in = 1'b1;
          end else if (acc) begin
            state_nxt = FULL;
            load_skid = 1'b1;
          end else if (con) begin
            state_nxt  = EMPTY;
            clear_main = 1'b1;
          end
        end
        FULL: begin
          if (con) begin
            state_nxt      = ONE;
            load_main_skid = 1'b1;
          end
        end
        default: begin
          state_nxt  = EMPTY;
          clear_main = 1'b1;
          clear_skid = 1'b1;
        end
      endcase
    end
  end

  // Payload only moves under acc, so X on idle inputs never reaches state
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state      <= EMPTY;
      main_pc    <= '0;
      main_instr <= NOP_INSTR;
      skid_pc    <= '0;
      skid_instr <= '0;
    end else begin
      state <= state_nxt;
      if (clear_main) begin
        main_pc    <= '0;
        main_instr <= NOP_INSTR;
      end else if (load_main_in) begin
        main_pc    <= in_pc;
        main_instr <= in_instr;
      end else if (load_main_skid) begin
        main_pc    <= skid_pc;
        main_instr <= skid_instr;
      end
      if (clear_skid) begin
        skid_pc    <= '0;
        skid_instr <= '0;
      end else if (load_skid) begin
        skid_pc    <= in_pc;
        skid_instr <= in_instr;
      end
    end
  end

  assign out_pc    = main_pc;
  assign out_instr = main_instr;
  assign out_type  = main_instr[TYPE_HI:TYPE_LO];
  assign out_op    = main_instr[OP_HI:OP_LO];
  assign state_dbg = state;

  pipe_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (in_valid & ~in_ready & ~flush),
    .cnt (stall_cnt)
  );

  pipe_sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk (clk),
    .rst (rst),
    .inc (out_ready & ~out_valid & ~flush),
    .cnt (bubble_cnt)
  );

endmodule

// File: tb/tb_if_id_elastic_stage.sv
// Directed bench for if_id_elastic_stage, built with 4-bit counters so
// saturation is reachable in a short run.
module tb_if_id_elastic_stage;
  import pipe_pkg::*;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_pc;
  logic [31:0]      in_instr;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_pc;
  logic [31:0]      out_instr;
  logic [1:0]       out_type;
  logic [4:0]       out_op;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] bubble_cnt;
  elastic_state_t   state_dbg;

  int checks = 0;
  int errors = 0;

  // Clock / reset
  always #5 clk = ~clk;

  if_id_elastic_stage #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pc      (in_pc),
    .in_instr   (in_instr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pc     (out_pc),
    .out_instr  (out_instr),
    .out_type   (out_type),
    .out_op     (out_op),
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt),
    .state_dbg  (state_dbg)
  );

  // Driver tasks
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] pc, input logic [31:0] instr);
    in_valid = 1'b1;
    in_pc    = pc;
    in_instr = instr;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_pc    = 'x;
    in_instr = 'x;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    idle();
    #12;
    rst = 1'b0;
    step();

    // Reset mid-FULL
    offer(32'h100, 32'h1111_1111); step();
    offer(32'h104, 32'h2222_2222); step();
    chk("full_state", 32'(state_dbg), 32'(FULL));
    chk("full_in_ready", 32'(in_ready), 32'd0);
    offer(32'h108, 32'h3333_3333); step();
    chk("full_stall", 32'(stall_cnt), 32'd1);
    chk("full_head", out_pc, 32'h100);
    #2; rst = 1'b1; idle(); #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_type_op", {25'd0, out_type, out_op}, 32'd0);
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    chk("rst_state", 32'(state_dbg), 32'(EMPTY));
    rst = 1'b0;
    step();
    chk("idle_x_pc", out_pc, 32'h0);

    // Streaming with out_ready high
    out_ready = 1'b1;
    offer(32'h0, 32'h8A00_0001); step();
    chk("str0_pc", out_pc, 32'h0);
    chk("str0_instr", out_instr, 32'h8A00_0001);
    chk("str0_type", 32'(out_type), 32'h2);
    chk("str0_op", 32'(out_op), 32'h5);
    chk("str0_bubble", 32'(bubble_cnt), 32'd1);
    offer(32'h4, 32'h8A00_0002); step();
    chk("str1_pc", out_pc, 32'h4);
    chk("str1_instr", out_instr, 32'h8A00_0002);
    offer(32'h8, 32'h8A00_0003); step();
    chk("str2_pc", out_pc, 32'h8);
    chk("str2_bubble", 32'(bubble_cnt), 32'd1);
    idle(); step();
    chk("str_drain_valid", 32'(out_valid), 32'd0);
    chk("str_drain_instr", out_instr, 32'h0);
    out_ready = 1'b0;

    // Back-pressure
    offer(32'h10, 32'hC000_0010); step();
    chk("bp_one_ready", 32'(in_ready), 32'd1);
    offer(32'h14, 32'hC000_0014); step();
    chk("bp_full_ready", 32'(in_ready), 32'd0);
    chk("bp_full_stall", 32'(stall_cnt), 32'd0);
    offer(32'h18, 32'hC000_0018); step();
    chk("bp_hold1_stall", 32'(stall_cnt), 32'd1);
    chk("bp_hold1_pc", out_pc, 32'h10);
    step();
    chk("bp_hold2_stall", 32'(stall_cnt), 32'd2);
    out_ready = 1'b1; step();
    chk("bp_rel1_pc", out_pc, 32'h14);
    chk("bp_rel1_instr", out_instr, 32'hC000_0014);
    chk("bp_rel1_stall", 32'(stall_cnt), 32'd3);
    step();
    chk("bp_rel2_pc", out_pc, 32'h18);
    chk("bp_rel2_state", 32'(state_dbg), 32'(ONE));
    idle(); step();
    chk("bp_drain_state", 32'(state_dbg), 32'(EMPTY));
    out_ready = 1'b0;

    // Flush in FULL with a simultaneous offer
    offer(32'h30, 32'h4000_0030); step();
    offer(32'h34, 32'h4000_0034); step();
    chk("fl_pre_state", 32'(state_dbg), 32'(FULL));
    offer(32'h20, 32'h4000_0020); flush = 1'b1; step();
    chk("fl_state", 32'(state_dbg), 32'(EMPTY));
    chk("fl_valid", 32'(out_valid), 32'd0);
    chk("fl_instr", out_instr, 32'h0);
    chk("fl_pc", out_pc, 32'h0);
    chk("fl_stall", 32'(stall_cnt), 32'd3);
    idle(); out_ready = 1'b1; step();
    chk("fl2_state", 32'(state_dbg), 32'(EMPTY));
    chk("fl2_bubble", 32'(bubble_cnt), 32'd1);
    flush = 1'b0; out_ready = 1'b0;

    // Accept and consume together in ONE
    offer(32'h40, 32'h0800_0040); step();
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      offer(32'h40 + 32'(4 * i), 32'h0800_0040 + 32'(4 * i)); step();
      chk("ac_state", 32'(state_dbg), 32'(ONE));
      chk("ac_pc", out_pc, 32'h40 + 32'(4 * i));
      chk("ac_instr", out_instr, 32'h0800_0040 + 32'(4 * i));
    end
    idle(); step();
    chk("ac_drain_state", 32'(state_dbg), 32'(EMPTY));
    chk("ac_bubble", 32'(bubble_cnt), 32'd1);
    out_ready = 1'b0;

    // Stall counter saturation (starts at 3)
    offer(32'h60, 32'h0000_0060); step();
    offer(32'h64, 32'h0000_0064); step();
    offer(32'h68, 32'h0000_0068);
    for (int i = 0; i < 11; i++) step();
    chk("sat_stall_e", 32'(stall_cnt), 32'hE);
    step();
    chk("sat_stall_f", 32'(stall_cnt), 32'hF);
    step(); step();
    chk("sat_stall_hold", 32'(stall_cnt), 32'hF);
    chk("sat_head", out_pc, 32'h60);

    // Bubble counter saturation (starts at 1)
    idle(); flush = 1'b1; step();
    flush = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 14; i++) step();
    chk("sat_bubble_f", 32'(bubble_cnt), 32'hF);
    step(); step();
    chk("sat_bubble_hold", 32'(bubble_cnt), 32'hF);
    chk("sat_stall_kept", 32'(stall_cnt), 32'hF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
